// File: rtl/vrf_operand_fetcher_pkg.sv
// Shared types and VRF geometry for the operand fetcher: request layout, FSM states,
// beat-count and VRF beat-address helpers.
package vrf_operand_fetcher_pkg;

  localparam int unsigned NrOpQueue    = 2;
  localparam int unsigned NrVRegs      = 32;
  localparam int unsigned VLENB        = 128;
  localparam int unsigned DataWB       = 8;
  localparam int unsigned BeatsPerReg  = VLENB / DataWB;
  localparam int unsigned VRFAddrWidth = $clog2(NrVRegs * BeatsPerReg);
  // vlB and the beat counters must cover a whole LMUL=8 register group
  localparam int unsigned VlbWidth     = $clog2(8 * VLENB) + 1;
  localparam int unsigned BeatCntWidth = $clog2(8 * BeatsPerReg) + 1;

  typedef logic [$clog2(NrVRegs)-1:0] vreg_t;
  typedef logic [BeatCntWidth-1:0]    beat_cnt_t;
  typedef logic [VRFAddrWidth-1:0]    vrf_addr_t;
  typedef logic [8*DataWB-1:0]        vrf_data_t;

  typedef struct packed {
    vreg_t                 vs1;
    vreg_t                 vs2;
    logic [NrOpQueue-1:0]  queue_req;
    logic [VlbWidth-1:0]   vlB;
  } op_req_t;

  typedef enum logic {
    IDLE,
    BUSY
  } fetch_state_e;

  function automatic vrf_addr_t GetVRFAddr(input vreg_t vs, input beat_cnt_t beat_idx);
    return vrf_addr_t'(vs) * vrf_addr_t'(BeatsPerReg) + vrf_addr_t'(beat_idx);
  endfunction

  // ceil(vlB / DataWB); a partial last beat is fetched whole
  function automatic beat_cnt_t NumBeats(input logic [VlbWidth-1:0] vlb);
    logic [VlbWidth:0] rounded;
    rounded = {1'b0, vlb} + (VlbWidth + 1)'(DataWB - 1);
    return beat_cnt_t'(rounded >> $clog2(DataWB));
  endfunction

endpackage

// File: rtl/vrf_operand_fetcher_if.sv
// Bundles the op_req channel, the VRF read port and the operand-queue push/pop signals.
// slave = operand fetcher, master = launcher / VRF arbiter / VFU consumers.
interface vrf_operand_fetcher_if;
  import vrf_operand_fetcher_pkg::*;

  logic                 op_req_valid_i;
  logic                 op_req_ready_o;
  op_req_t              op_req_i;
  logic                 vrf_rd_req_o;
  vrf_addr_t            vrf_rd_addr_o;
  logic                 vrf_rd_gnt_i;
  vrf_data_t            vrf_rd_data_i;
  logic [NrOpQueue-1:0] opq_push_o;
  vrf_data_t            opq_data_o;
  logic [NrOpQueue-1:0] opq_pop_i;

  modport slave (
    input  op_req_valid_i, op_req_i, vrf_rd_gnt_i, vrf_rd_data_i, opq_pop_i,
    output op_req_ready_o, vrf_rd_req_o, vrf_rd_addr_o, opq_push_o, opq_data_o
  );

  modport master (
    output op_req_valid_i, op_req_i, vrf_rd_gnt_i, vrf_rd_data_i, opq_pop_i,
    input  op_req_ready_o, vrf_rd_req_o, vrf_rd_addr_o, opq_push_o, opq_data_o
  );

endinterface

// File: rtl/vrf_operand_fetcher_opq_credit_counter.sv
// Per-queue credit counter: starts full, +1 on consumer pop, -1 on VRF grant to this queue.
module vrf_operand_fetcher_opq_credit_counter #(
  parameter  int unsigned QueueDepth  = 4,
  localparam int unsigned CreditWidth = $clog2(QueueDepth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_inc,
  input  logic                   i_dec,
  output logic [CreditWidth-1:0] o_credit
);

  logic [CreditWidth-1:0] r_credit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_credit <= CreditWidth'(QueueDepth);
    end else if (i_inc && !i_dec) begin
      r_credit <= r_credit + CreditWidth'(1);
    end else if (i_dec && !i_inc) begin
      r_credit <= r_credit - CreditWidth'(1);
    end
  end

  assign o_credit = r_credit;

  a_credit_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_credit <= CreditWidth'(QueueDepth));

endmodule

// File: rtl/vrf_operand_fetcher.sv
// Walks vs1/vs2 of an accepted op_req over the single VRF read port and pushes the
// returned beats into the per-source operand queues under credit flow control.
//   state | meaning
//   IDLE  | ready for a new op_req
//   BUSY  | issuing reads, then draining the last in-flight beat
module vrf_operand_fetcher
  import vrf_operand_fetcher_pkg::*;
#(
  parameter int unsigned QueueDepth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  vrf_operand_fetcher_if.slave  bus,
  output logic                  busy_o
);

  localparam int unsigned CreditWidth = $clog2(QueueDepth + 1);

  fetch_state_e r_state, w_state_nxt;

  vreg_t     [NrOpQueue-1:0]                  r_vs;
  beat_cnt_t [NrOpQueue-1:0]                  r_remaining;
  beat_cnt_t [NrOpQueue-1:0]                  r_beat_idx;
  logic      [NrOpQueue-1:0][CreditWidth-1:0] w_credit;

  logic                 r_inflight_vld;
  logic                 r_inflight_tag;
  logic                 r_hold_vld;
  logic                 r_hold_tag;
  logic                 r_pick_vs2;
  logic [NrOpQueue-1:0] w_eligible;
  logic [NrOpQueue-1:0] w_gnt_q;
  logic                 w_sel;
  logic                 w_rd_req;
  logic                 w_grant;
  logic                 w_accept;
  logic                 w_all_done;
  beat_cnt_t            w_req_beats;

  assign w_req_beats = NumBeats(bus.op_req_i.vlB);
  assign w_all_done  = (r_remaining[0] == '0) && (r_remaining[1] == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.op_req_valid_i && (|bus.op_req_i.queue_req) && (w_req_beats != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_all_done) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  for (genvar g = 0; g < NrOpQueue; g++) begin : g_queue
    assign w_eligible[g] = (r_remaining[g] != '0) && (w_credit[g] != '0);
    assign w_gnt_q[g]    = w_grant && (w_sel == 1'(g));

    vrf_operand_fetcher_opq_credit_counter #(
      .QueueDepth (QueueDepth)
    ) i_credit (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .i_inc    (bus.opq_pop_i[g]),
      .i_dec    (w_gnt_q[g]),
      .o_credit (w_credit[g])
    );
  end

  // A stalled request keeps its queue until granted, so a pop on the other queue
  // cannot move the address while the arbiter is waiting.
  always_comb begin
    if (r_hold_vld) begin
      w_sel = r_hold_tag;
    end else if (&w_eligible) begin
      w_sel = r_pick_vs2;
    end else begin
      w_sel = w_eligible[1];
    end
  end

  assign w_rd_req = (r_state == BUSY) && (r_hold_vld || (|w_eligible));
  assign w_grant  = w_rd_req && bus.vrf_rd_gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vs        <= '0;
      r_remaining <= '0;
      r_beat_idx  <= '0;
    end else if (w_accept) begin
      r_vs[0] <= bus.op_req_i.vs1;
      r_vs[1] <= bus.op_req_i.vs2;
      for (int unsigned q = 0; q < NrOpQueue; q++) begin
        r_remaining[q] <= bus.op_req_i.queue_req[q] ? w_req_beats : '0;
        r_beat_idx[q]  <= '0;
      end
    end else begin
      for (int unsigned q = 0; q < NrOpQueue; q++) begin
        if (w_gnt_q[q]) begin
          r_remaining[q] <= r_remaining[q] - beat_cnt_t'(1);
          r_beat_idx[q]  <= r_beat_idx[q] + beat_cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_inflight_vld <= 1'b0;
      r_inflight_tag <= 1'b0;
      r_hold_vld     <= 1'b0;
      r_hold_tag     <= 1'b0;
      r_pick_vs2     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_inflight_vld <= w_grant;
      r_inflight_tag <= w_sel;
      r_hold_vld     <= w_rd_req && !bus.vrf_rd_gnt_i;
      r_hold_tag     <= w_sel;
      if (w_accept) begin
        r_pick_vs2 <= 1'b0;
      end else if (w_grant) begin
        r_pick_vs2 <= ~w_sel;
      end
    end
  end

  assign bus.op_req_ready_o = (r_state == IDLE);
  assign bus.vrf_rd_req_o   = w_rd_req;
  assign bus.vrf_rd_addr_o  = GetVRFAddr(r_vs[w_sel], r_beat_idx[w_sel]);
  assign bus.opq_push_o     = r_inflight_vld ? (NrOpQueue'(1) << r_inflight_tag) : '0;
  assign bus.opq_data_o     = bus.vrf_rd_data_i;
  assign busy_o             = (r_state == BUSY) || r_inflight_vld;

endmodule

// File: tb/tb_vrf_operand_fetcher.sv
// Directed bench for vrf_operand_fetcher: fixed request vectors with hand-computed
// addresses, push strobes and stall points; a small VRF model returns tagged data.
module tb_vrf_operand_fetcher;
  import vrf_operand_fetcher_pkg::*;

  localparam int unsigned QueueDepth = 4;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic busy_o;

  vrf_operand_fetcher_if bus ();

  vrf_operand_fetcher #(
    .QueueDepth (QueueDepth)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int n_grants;

  logic                 seen_gnt;
  vrf_addr_t            seen_addr;
  logic [NrOpQueue-1:0] seen_push;
  bit                   auto_pop;

  vrf_addr_t t1_addr [8] = '{9'd32, 9'd80, 9'd33, 9'd81, 9'd34, 9'd82, 9'd35, 9'd83};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic vrf_data_t rd_word(input vrf_addr_t a);
    return 64'hDA7A_5EED_0000_0000 | 64'(a);
  endfunction

  function automatic op_req_t mk_req(input int vs1, input int vs2, input logic [1:0] qr, input int vlb);
    op_req_t r;
    r.vs1       = vreg_t'(vs1);
    r.vs2       = vreg_t'(vs2);
    r.queue_req = qr;
    r.vlB       = VlbWidth'(vlb);
    return r;
  endfunction

  // VRF returns data one cycle after a grant; consumer optionally pops one cycle after a push
  always @(negedge clk_i) begin
    seen_gnt  = bus.vrf_rd_req_o && bus.vrf_rd_gnt_i;
    seen_addr = bus.vrf_rd_addr_o;
    seen_push = bus.opq_push_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    bus.vrf_rd_data_i = seen_gnt ? rd_word(seen_addr) : 64'h0;
    bus.opq_pop_i     = auto_pop ? seen_push : 2'b00;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] exp_push;
    rst_ni               = 1'b0;
    auto_pop             = 1'b1;
    bus.op_req_valid_i   = 1'b0;
    bus.op_req_i         = '0;
    bus.vrf_rd_gnt_i     = 1'b0;
    bus.vrf_rd_data_i    = '0;
    bus.opq_pop_i        = '0;
    #2;
    check_eq("rst ready", 64'(bus.op_req_ready_o), 64'd1);
    check_eq("rst rd_req", 64'(bus.vrf_rd_req_o), 64'd0);
    check_eq("rst push", 64'(bus.opq_push_o), 64'd0);
    check_eq("rst busy", 64'(busy_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;

    // both queues, vs1=2 vs2=5, 4 beats each, alternating
    tick();
    bus.op_req_i       = mk_req(2, 5, 2'b11, 32);
    bus.op_req_valid_i = 1'b1;
    bus.vrf_rd_gnt_i   = 1'b1;
    #1;
    check_eq("t1 accept ready", 64'(bus.op_req_ready_o), 64'd1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      bus.op_req_valid_i = 1'b0;
      #1;
      check_eq($sformatf("t1 req c%0d", c), 64'(bus.vrf_rd_req_o), 64'(c <= 8));
      if (c <= 8) check_eq($sformatf("t1 addr c%0d", c), 64'(bus.vrf_rd_addr_o), 64'(t1_addr[c-1]));
      exp_push = (c >= 2) ? (((c % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      check_eq($sformatf("t1 push c%0d", c), 64'(bus.opq_push_o), 64'(exp_push));
      if (c >= 2) check_eq($sformatf("t1 data c%0d", c), 64'(bus.opq_data_o), 64'(rd_word(t1_addr[c-2])));
      check_eq($sformatf("t1 ready c%0d", c), 64'(bus.op_req_ready_o), 64'd0);
      check_eq($sformatf("t1 busy c%0d", c), 64'(busy_o), 64'd1);
    end

    // cycle 10: back in IDLE, next request (vs1 only, vlB=17 -> 3 beats) taken at once
    tick();
    bus.op_req_i       = mk_req(7, 0, 2'b01, 17);
    bus.op_req_valid_i = 1'b1;
    #1;
    check_eq("t1 idle ready", 64'(bus.op_req_ready_o), 64'd1);
    check_eq("t1 idle busy", 64'(busy_o), 64'd0);
    check_eq("t1 idle push", 64'(bus.opq_push_o), 64'd0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.op_req_valid_i = 1'b0;
      #1;
      check_eq($sformatf("t2 req c%0d", c), 64'(bus.vrf_rd_req_o), 64'(c <= 3));
      if (c <= 3) check_eq($sformatf("t2 addr c%0d", c), 64'(bus.vrf_rd_addr_o), 64'(112 + c - 1));
      check_eq($sformatf("t2 push c%0d", c), 64'(bus.opq_push_o), 64'((c >= 2 && c <= 4) ? 1 : 0));
      if (c >= 2 && c <= 4) check_eq($sformatf("t2 data c%0d", c), 64'(bus.opq_data_o), 64'(rd_word(vrf_addr_t'(112 + c - 2))));
      check_eq($sformatf("t2 ready c%0d", c), 64'(bus.op_req_ready_o), 64'(c >= 5));
    end

    // zero-beat requests are absorbed without leaving IDLE
    for (int k = 0; k <= 3; k++) begin
      tick();
      bus.op_req_valid_i = (k <= 2);
      bus.op_req_i       = (k < 2) ? mk_req(1, 1, 2'b11, 0) : mk_req(1, 1, 2'b00, 32);
      #1;
      check_eq($sformatf("t3 ready k%0d", k), 64'(bus.op_req_ready_o), 64'd1);
      check_eq($sformatf("t3 req k%0d", k), 64'(bus.vrf_rd_req_o), 64'd0);
      check_eq($sformatf("t3 busy k%0d", k), 64'(busy_o), 64'd0);
    end
    auto_pop = 1'b0;

    // credit stall: vs2=3 only, 8 beats, no pops -> 4 grants, then one pop -> one read
    tick();
    bus.op_req_i       = mk_req(0, 3, 2'b10, 64);
    bus.op_req_valid_i = 1'b1;
    #1;
    check_eq("t4 accept ready", 64'(bus.op_req_ready_o), 64'd1);
    n_grants = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.op_req_valid_i = 1'b0;
      if (c == 8) bus.opq_pop_i = 2'b10;
      #1;
      n_grants += int'(bus.vrf_rd_req_o && bus.vrf_rd_gnt_i);
      check_eq($sformatf("t4 req c%0d", c), 64'(bus.vrf_rd_req_o), 64'(c <= 4));
      if (c <= 4) check_eq($sformatf("t4 addr c%0d", c), 64'(bus.vrf_rd_addr_o), 64'(48 + c - 1));
      check_eq($sformatf("t4 push c%0d", c), 64'(bus.opq_push_o), 64'((c >= 2 && c <= 5) ? 2 : 0));
      check_eq($sformatf("t4 busy c%0d", c), 64'(busy_o), 64'd1);
    end
    check_eq("t4 grants before pop", 64'(n_grants), 64'd4);
    tick();
    #1;
    check_eq("t4 req after pop", 64'(bus.vrf_rd_req_o), 64'd1);
    check_eq("t4 addr after pop", 64'(bus.vrf_rd_addr_o), 64'd52);
    tick();
    #1;
    check_eq("t4 req stall again", 64'(bus.vrf_rd_req_o), 64'd0);
    check_eq("t4 push beat4", 64'(bus.opq_push_o), 64'd2);
    check_eq("t4 data beat4", 64'(bus.opq_data_o), 64'(rd_word(9'd52)));

    // grant withheld 5 cycles: request/address stable, nothing pushed, credit untouched
    tick();
    bus.opq_pop_i    = 2'b10;
    bus.vrf_rd_gnt_i = 1'b0;
    #1;
    check_eq("t5 req before credit", 64'(bus.vrf_rd_req_o), 64'd0);
    for (int c = 12; c <= 16; c++) begin
      tick();
      #1;
      check_eq($sformatf("t5 hold req c%0d", c), 64'(bus.vrf_rd_req_o), 64'd1);
      check_eq($sformatf("t5 hold addr c%0d", c), 64'(bus.vrf_rd_addr_o), 64'd53);
      check_eq($sformatf("t5 hold push c%0d", c), 64'(bus.opq_push_o), 64'd0);
    end
    tick();
    bus.vrf_rd_gnt_i = 1'b1;
    #1;
    check_eq("t5 gnt req", 64'(bus.vrf_rd_req_o), 64'd1);
    check_eq("t5 gnt addr", 64'(bus.vrf_rd_addr_o), 64'd53);
    tick();
    bus.opq_pop_i = 2'b10;
    #1;
    check_eq("t5 single grant", 64'(bus.vrf_rd_req_o), 64'd0);
    check_eq("t5 push", 64'(bus.opq_push_o), 64'd2);
    check_eq("t5 data", 64'(bus.opq_data_o), 64'(rd_word(9'd53)));

    // reset while a read is in flight
    tick();
    #1;
    check_eq("t6 req", 64'(bus.vrf_rd_req_o), 64'd1);
    check_eq("t6 addr", 64'(bus.vrf_rd_addr_o), 64'd54);
    tick();
    #1;
    check_eq("t6 inflight push", 64'(bus.opq_push_o), 64'd2);
    rst_ni = 1'b0;
    #1;
    check_eq("t6 rst push", 64'(bus.opq_push_o), 64'd0);
    check_eq("t6 rst ready", 64'(bus.op_req_ready_o), 64'd1);
    check_eq("t6 rst busy", 64'(busy_o), 64'd0);
    check_eq("t6 rst req", 64'(bus.vrf_rd_req_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    #1;
    check_eq("t6 next push", 64'(bus.opq_push_o), 64'd0);
    check_eq("t6 next ready", 64'(bus.op_req_ready_o), 64'd1);

    // vs2 credits must be back to QueueDepth and beat index back to 0
    tick();
    bus.op_req_i       = mk_req(0, 9, 2'b10, 64);
    bus.op_req_valid_i = 1'b1;
    #1;
    check_eq("t6 accept ready", 64'(bus.op_req_ready_o), 64'd1);
    n_grants = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus.op_req_valid_i = 1'b0;
      #1;
      n_grants += int'(bus.vrf_rd_req_o && bus.vrf_rd_gnt_i);
      check_eq($sformatf("t6 req c%0d", c), 64'(bus.vrf_rd_req_o), 64'(c <= 4));
      if (c <= 4) check_eq($sformatf("t6 addr c%0d", c), 64'(bus.vrf_rd_addr_o), 64'(144 + c - 1));
    end
    check_eq("t6 grants after reset", 64'(n_grants), 64'(QueueDepth));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
